// File: rtl/muldiv_pkg.sv
// Shared RV32M definitions: ALUOP codes, state encoding, widths.
// Imported by control_unit, alu and the multi-cycle mul/div unit.
package muldiv_pkg;

    localparam int XLEN  = 32;
    localparam int ITERS = 32;

    localparam logic [4:0] ALUOP_MUL    = 5'b01001;
    localparam logic [4:0] ALUOP_MULH   = 5'b01010;
    localparam logic [4:0] ALUOP_MULHU  = 5'b01011;
    localparam logic [4:0] ALUOP_MULHSU = 5'b01100;
    localparam logic [4:0] ALUOP_DIV    = 5'b01101;
    localparam logic [4:0] ALUOP_DIVU   = 5'b01110;
    localparam logic [4:0] ALUOP_REM    = 5'b01111;
    localparam logic [4:0] ALUOP_REMU   = 5'b10000;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CALC   = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    function automatic logic is_muldiv(input logic [4:0] op);
        return (op >= ALUOP_MUL) && (op <= ALUOP_REMU);
    endfunction

    function automatic logic is_mul(input logic [4:0] op);
        return (op >= ALUOP_MUL) && (op <= ALUOP_MULHSU);
    endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Sign handling around the unsigned iterative core: operand magnitudes
// on entry, sign correction and RISC-V special results on exit.
module muldiv_sign_fix #(
    parameter int XLEN = muldiv_pkg::XLEN
) (
    input  logic [4:0]        start_op,
    input  logic [XLEN-1:0]   data1,
    input  logic [XLEN-1:0]   data2,
    output logic [XLEN-1:0]   mag1,
    output logic [XLEN-1:0]   mag2,
    output logic              sgn1,
    output logic              sgn2,
    output logic              dzero,
    output logic              dovf,
    input  logic [4:0]        op,
    input  logic              s1,
    input  logic              s2,
    input  logic              zero,
    input  logic              ovf,
    input  logic [XLEN-1:0]   m1,
    input  logic [2*XLEN-1:0] acc,
    output logic [XLEN-1:0]   result
);
    import muldiv_pkg::*;

    localparam logic [XLEN-1:0] MINV = {1'b1, {(XLEN-1){1'b0}}};

    logic              signed1;
    logic              signed2;
    logic              isdiv;
    logic              sdiv;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   rem;
    logic [XLEN-1:0]   dvd;

    // Magnitudes, sign flags and divide special-case flags for START
    always_comb begin
        signed1 = (start_op == ALUOP_MUL) || (start_op == ALUOP_MULH) ||
                  (start_op == ALUOP_MULHSU) || (start_op == ALUOP_DIV) ||
                  (start_op == ALUOP_REM);
        signed2 = (start_op == ALUOP_MUL) || (start_op == ALUOP_MULH) ||
                  (start_op == ALUOP_DIV) || (start_op == ALUOP_REM);
        sdiv    = (start_op == ALUOP_DIV) || (start_op == ALUOP_REM);
        isdiv   = is_muldiv(start_op) && !is_mul(start_op);
        sgn1    = signed1 & data1[XLEN-1];
        sgn2    = signed2 & data2[XLEN-1];
        mag1    = sgn1 ? -data1 : data1;
        mag2    = sgn2 ? -data2 : data2;
        dzero   = isdiv && (data2 == '0);
        dovf    = sdiv && (data1 == MINV) && (data2 == '1);
    end

    // Sign correction and special-case selection for FINISH
    always_comb begin
        prod   = (s1 ^ s2) ? -acc : acc;
        quo    = (s1 ^ s2) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rem    = s1 ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        dvd    = s1 ? -m1 : m1;
        result = '0;
        unique case (1'b1)
            (op == ALUOP_MUL):
                result = prod[XLEN-1:0];
            (op == ALUOP_MULH) || (op == ALUOP_MULHU) ||
            (op == ALUOP_MULHSU):
                result = prod[2*XLEN-1:XLEN];
            (op == ALUOP_DIV) || (op == ALUOP_DIVU):
                result = zero ? '1 : (ovf ? MINV : quo);
            (op == ALUOP_REM) || (op == ALUOP_REMU):
                result = zero ? dvd : (ovf ? '0 : rem);
            default:
                result = '0;
        endcase
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage.
// Fixed 33-cycle latency; BUSY stalls the front of the pipe until DONE.
module muldiv_unit #(
    parameter int XLEN  = muldiv_pkg::XLEN,
    parameter int ITERS = muldiv_pkg::ITERS
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            START,
    input  logic [4:0]      ALUOP,
    input  logic [XLEN-1:0] DATA1,
    input  logic [XLEN-1:0] DATA2,
    input  logic            FLUSH,
    output logic            BUSY,
    output logic            DONE,
    output logic [XLEN-1:0] RESULT
);
    import muldiv_pkg::*;

    localparam int            CW   = $clog2(ITERS);
    localparam logic [CW-1:0] LAST = CW'(ITERS - 1);

    state_t            state_q;
    state_t            state_d;
    logic              accept;
    logic [4:0]        op_q;
    logic [XLEN-1:0]   m1_q;
    logic [XLEN-1:0]   m2_q;
    logic              s1_q;
    logic              s2_q;
    logic              zero_q;
    logic              ovf_q;
    logic [2*XLEN-1:0] acc_q;
    logic [2*XLEN-1:0] acc_step;
    logic [CW-1:0]     cnt_q;
    logic [XLEN:0]     madd;
    logic [XLEN:0]     rtry;
    logic [XLEN:0]     rsub;
    logic [XLEN-1:0]   mag1;
    logic [XLEN-1:0]   mag2;
    logic              sgn1;
    logic              sgn2;
    logic              dzero;
    logic              dovf;
    logic [XLEN-1:0]   fix_result;

    muldiv_sign_fix #(.XLEN(XLEN)) u_fix (
        .start_op (ALUOP),
        .data1    (DATA1),
        .data2    (DATA2),
        .mag1     (mag1),
        .mag2     (mag2),
        .sgn1     (sgn1),
        .sgn2     (sgn2),
        .dzero    (dzero),
        .dovf     (dovf),
        .op       (op_q),
        .s1       (s1_q),
        .s2       (s2_q),
        .zero     (zero_q),
        .ovf      (ovf_q),
        .m1       (m1_q),
        .acc      (acc_q),
        .result   (fix_result)
    );

    assign accept = (state_q == S_IDLE) && START && !FLUSH &&
                    is_muldiv(ALUOP);
    assign BUSY   = (state_q != S_IDLE);

    // State register
    always_ff @(posedge CLK) begin
        if (RESET) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state: accept, iterate ITERS times, finish; FLUSH aborts
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (accept) state_d = S_CALC;
            S_CALC: begin
                if (FLUSH)              state_d = S_IDLE;
                else if (cnt_q == LAST) state_d = S_FINISH;
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // One iteration: shift-add for multiply, restoring step for divide.
    // acc holds {partial product, multiplier} or {remainder, quotient}.
    always_comb begin
        madd = {1'b0, acc_q[2*XLEN-1:XLEN]} +
               (acc_q[0] ? {1'b0, m1_q} : '0);
        rtry = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        rsub = rtry - {1'b0, m2_q};
        if (is_mul(op_q))
            acc_step = {madd, acc_q[XLEN-1:1]};
        else if (rsub[XLEN])
            acc_step = {rtry[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        else
            acc_step = {rsub[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    end

    // Operand latch on accept, iterative datapath and counter in CALC
    always_ff @(posedge CLK) begin
        if (RESET) begin
            op_q   <= '0;
            m1_q   <= '0;
            m2_q   <= '0;
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            zero_q <= 1'b0;
            ovf_q  <= 1'b0;
            acc_q  <= '0;
            cnt_q  <= '0;
        end else if (accept) begin
            op_q   <= ALUOP;
            m1_q   <= mag1;
            m2_q   <= mag2;
            s1_q   <= sgn1;
            s2_q   <= sgn2;
            zero_q <= dzero;
            ovf_q  <= dovf;
            acc_q  <= {{XLEN{1'b0}}, (is_mul(ALUOP) ? mag2 : mag1)};
            cnt_q  <= '0;
        end else if (state_q == S_CALC) begin
            acc_q  <= acc_step;
            cnt_q  <= cnt_q + CW'(1);
        end
    end

    // Result write and one-cycle DONE pulse, suppressed by FLUSH
    always_ff @(posedge CLK) begin
        if (RESET) begin
            DONE   <= 1'b0;
            RESULT <= '0;
        end else begin
            DONE <= 1'b0;
            if (state_q == S_FINISH && !FLUSH) begin
                DONE   <= 1'b1;
                RESULT <= fix_result;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: vector table plus hand-written
// sequences for flush, reset, invalid op, busy and back-to-back starts.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        START;
    logic [4:0]  ALUOP;
    logic [31:0] DATA1;
    logic [31:0] DATA2;
    logic        FLUSH;
    logic        BUSY;
    logic        DONE;
    logic [31:0] RESULT;

    int errs   = 0;
    int checks = 0;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] exp;
    } vec_t;

    localparam int NV = 17;
    vec_t vt[NV];

    muldiv_unit dut (
        .CLK    (CLK),
        .RESET  (RESET),
        .START  (START),
        .ALUOP  (ALUOP),
        .DATA1  (DATA1),
        .DATA2  (DATA2),
        .FLUSH  (FLUSH),
        .BUSY   (BUSY),
        .DONE   (DONE),
        .RESULT (RESULT)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Issue one op and wait for DONE. now=1 drives START in the current
    // cycle (back-to-back); inj>0 pulses a stray START that many edges in.
    task automatic do_op(input logic [4:0] op, input logic [31:0] d1,
                         input logic [31:0] d2, input logic [31:0] exp,
                         input bit now, input int inj, input string nm);
        int edges;
        bit busy_ok;
        if (!now) @(negedge CLK);
        START = 1'b1;
        ALUOP = op;
        DATA1 = d1;
        DATA2 = d2;
        @(posedge CLK);
        #1;
        START   = 1'b0;
        ALUOP   = ALUOP_MUL;
        DATA1   = $urandom;
        DATA2   = $urandom;
        edges   = 0;
        busy_ok = BUSY;
        while (!DONE && edges < 100) begin
            if (inj != 0 && edges == inj) begin
                START = 1'b1;
                DATA1 = 32'h5;
                DATA2 = 32'h3;
            end
            @(posedge CLK);
            #1;
            START = 1'b0;
            edges++;
            if (!DONE && !BUSY) busy_ok = 1'b0;
        end
        check({nm, " latency"}, edges, 33);
        check({nm, " result"}, RESULT, exp);
        check({nm, " busy"}, {31'd0, busy_ok}, 32'd1);
        check({nm, " busy@done"}, {31'd0, BUSY}, 32'd0);
    endtask

    initial begin
        logic [31:0] prev;
        bit          seen;

        vt[0]  = '{ALUOP_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB};
        vt[1]  = '{ALUOP_MULH,   32'h80000000, 32'h80000000, 32'h40000000};
        vt[2]  = '{ALUOP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
        vt[3]  = '{ALUOP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
        vt[4]  = '{ALUOP_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD};
        vt[5]  = '{ALUOP_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF};
        vt[6]  = '{ALUOP_DIVU,   32'd100,      32'd7,        32'd14};
        vt[7]  = '{ALUOP_REMU,   32'd100,      32'd7,        32'd2};
        vt[8]  = '{ALUOP_DIVU,   32'd100,      32'd0,        32'hFFFFFFFF};
        vt[9]  = '{ALUOP_REM,    32'd100,      32'd0,        32'd100};
        vt[10] = '{ALUOP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000};
        vt[11] = '{ALUOP_REM,    32'h80000000, 32'hFFFFFFFF, 32'd0};
        vt[12] = '{ALUOP_DIV,    32'hFFFFFF9C, 32'd0,        32'hFFFFFFFF};
        vt[13] = '{ALUOP_REM,    32'hFFFFFF9C, 32'd0,        32'hFFFFFF9C};
        vt[14] = '{ALUOP_MUL,    32'h12345678, 32'h10,       32'h23456780};
        vt[15] = '{ALUOP_DIV,    32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD};
        vt[16] = '{ALUOP_REM,    32'd7,        32'hFFFFFFFE, 32'd1};

        RESET = 1'b1;
        START = 1'b0;
        FLUSH = 1'b0;
        ALUOP = '0;
        DATA1 = '0;
        DATA2 = '0;
        repeat (2) @(posedge CLK);
        #1;
        check("reset busy", {31'd0, BUSY}, 32'd0);
        check("reset done", {31'd0, DONE}, 32'd0);
        check("reset result", RESULT, 32'd0);
        @(negedge CLK);
        RESET = 1'b0;

        for (int i = 0; i < NV; i++)
            do_op(vt[i].op, vt[i].d1, vt[i].d2, vt[i].exp, 1'b0, 0,
                  $sformatf("vec%0d", i));

        // Flush at edge N+10, then a start in the very next cycle
        prev = RESULT;
        @(negedge CLK);
        START = 1'b1;
        ALUOP = ALUOP_MUL;
        DATA1 = 32'd3;
        DATA2 = 32'd5;
        @(posedge CLK);
        #1;
        START = 1'b0;
        repeat (9) @(posedge CLK);
        @(negedge CLK);
        FLUSH = 1'b1;
        @(posedge CLK);
        #1;
        FLUSH = 1'b0;
        check("flush busy", {31'd0, BUSY}, 32'd0);
        check("flush done", {31'd0, DONE}, 32'd0);
        check("flush result", RESULT, prev);
        do_op(ALUOP_DIVU, 32'd1000, 32'd9, 32'd111, 1'b1, 0, "postflush");

        // Flush beats START in IDLE
        @(negedge CLK);
        START = 1'b1;
        FLUSH = 1'b1;
        ALUOP = ALUOP_MUL;
        @(posedge CLK);
        #1;
        START = 1'b0;
        FLUSH = 1'b0;
        check("idle flush busy", {31'd0, BUSY}, 32'd0);

        // Reset at edge N+5
        @(negedge CLK);
        START = 1'b1;
        ALUOP = ALUOP_DIV;
        DATA1 = 32'd50;
        DATA2 = 32'd5;
        @(posedge CLK);
        #1;
        START = 1'b0;
        repeat (4) @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        check("midreset busy", {31'd0, BUSY}, 32'd0);
        check("midreset done", {31'd0, DONE}, 32'd0);
        check("midreset result", RESULT, 32'd0);
        @(negedge CLK);
        RESET = 1'b0;

        // Unrecognised ALUOP (ADD) is ignored
        @(negedge CLK);
        START = 1'b1;
        ALUOP = 5'b00001;
        @(posedge CLK);
        #1;
        START = 1'b0;
        check("badop busy", {31'd0, BUSY}, 32'd0);
        seen = 1'b0;
        repeat (40) begin
            @(posedge CLK);
            #1;
            seen |= DONE;
        end
        check("badop done", {31'd0, seen}, 32'd0);

        // Stray START while busy, then back-to-back on the DONE cycle
        do_op(ALUOP_DIVU, 32'd100, 32'd7, 32'd14, 1'b0, 5, "busystart");
        do_op(ALUOP_MULHU, 32'h00010000, 32'h00030000, 32'd3, 1'b1, 0,
              "b2b");

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Multi-cycle RV32M execution unit in the EX stage, beside the main ALU. It consumes the ALUOP codes the control unit produces for MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU. It computes the result iteratively with a fixed latency. It raises BUSY so the hazard logic stalls IF/ID/EX until DONE.

Parameters:
XLEN, 32, operand/result width
ITERS, 32, iteration count (must equal XLEN)

Ports:
CLK  in  1  clock, rising edge
RESET  in  1  synchronous, active-high reset
START  in  1  request; sampled only in IDLE
ALUOP  in  5  operation code, valid with START
DATA1  in  XLEN  rs1 operand (dividend / multiplicand)
DATA2  in  XLEN  rs2 operand (divisor / multiplier)
FLUSH  in  1  abort the in-flight op (branch/jump flush)
BUSY  out  1  operation in progress; pipeline stall request
DONE  out  1  one-cycle result-valid pulse
RESULT  out  XLEN  result; holds its value until the next accepted START

Behaviour:
- Clock, reset and flush:
  - One clock, CLK. Reset is synchronous and active-high (RESET); no asynchronous paths.
  - RESET, including mid-operation: state returns to IDLE, and BUSY=0, DONE=0, RESULT=0, counter=0.
- Recognised ALUOP codes: MUL=01001, MULH=01010, MULHU=01011, MULHSU=01100, DIV=01101, DIVU=01110, REM=01111, REMU=10000.
  - START with any other code is ignored; the unit stays in IDLE.
- States: IDLE -> CALC -> FINISH -> IDLE.
  - IDLE and START and valid code at edge N: latch op, operand magnitudes, sign flags and zero/overflow flags. Clear the 64-bit accumulator, set counter=0, go to CALC. BUSY=1 from edge N.
  - CALC: one iteration per edge. Leave after the 32nd iteration (edges N+1..N+32), going to FINISH.
  - FINISH, edge N+33: apply sign correction and special cases, write RESULT, DONE=1, BUSY=0, go to IDLE.
  - DONE falls at edge N+34.
  - Latency is fixed at 33 edges from START to DONE for every op, including special cases.
- Handshake:
  - START while BUSY is ignored.
  - START in the same cycle DONE is high is accepted (back-to-back).
- FLUSH:
  - In CALC or FINISH: return to IDLE at that edge, BUSY=0, no DONE pulse, RESULT unchanged.
  - In IDLE with START: FLUSH wins; the op is not accepted.
- Multiply:
  - Unsigned shift-add on magnitudes produces a 64-bit product.
  - Negate in FINISH if the operand signs differ.
  - Operand signedness: MUL and MULH signed x signed; MULHSU signed rs1 x unsigned rs2; MULHU unsigned x unsigned.
  - MUL returns the low word; MULH, MULHSU and MULHU return the high word.
- Divide:
  - Restoring division on magnitudes, one quotient bit per iteration.
  - Signed quotient is negated if the operand signs differ.
  - Signed remainder takes the sign of the dividend.
- Special cases, resolved in FINISH:
  - Divisor 0: quotient = all ones; remainder = DATA1 unmodified.
  - Signed overflow (0x80000000 / 0xFFFFFFFF): quotient = 0x80000000, remainder = 0.
- Operands are latched at START; later DATA1/DATA2 changes have no effect.

Decomposition:
- Shared package: ALUOP code constants (shared with control_unit and alu), state encoding, XLEN.
- One sub-module is natural: muldiv_sign_fix, purely combinational. It performs magnitude extraction at START and negation/special-case selection at FINISH. The FSM, counter and iterative datapath stay in muldiv_unit.

Test Plan:
- MUL, DATA1=7, DATA2=0xFFFFFFFD -> DONE at edge N+33, RESULT=0xFFFFFFEB; BUSY high for edges N..N+32.
- MULH 0x80000000 x 0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD. REM of the same operands -> 0xFFFFFFFF. DIVU 100 / 7 -> 14. REMU 100 / 7 -> 2.
- DIVU 100 / 0 -> 0xFFFFFFFF. REM 100 / 0 -> 100. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000. REM of the same operands -> 0.
- START of MUL, FLUSH at edge N+10 -> BUSY=0 after that edge, no DONE, RESULT keeps its prior value. A START in the next cycle is accepted normally.
- RESET at edge N+5 -> all outputs 0. START with ALUOP=00001 (ADD) -> BUSY stays 0. START while BUSY -> ignored, first result unaffected. Back-to-back START on the DONE cycle -> second DONE exactly 33 edges later.
